// File: rtl/sdram_mem_arbiter.sv
// sdram_mem_arbiter: round-robin arbiter between a read-only fetch client and a
// read/write data client, driving one SDRAM controller transaction at a time.
module sdram_mem_arbiter #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 128
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              ifetch_req,
    input  logic [ADDR_W-1:0] ifetch_address,
    output logic              ofetch_accept,
    output logic              ofetch_valid,
    output logic [DATA_W-1:0] ofetch_data,
    input  logic              idata_req,
    input  logic              idata_we,
    input  logic [ADDR_W-1:0] idata_address,
    input  logic [DATA_W-1:0] idata_wdata,
    output logic              odata_accept,
    output logic              odata_valid,
    output logic [DATA_W-1:0] odata_rdata,
    output logic              oread_req,
    output logic [ADDR_W-1:0] oread_address,
    input  logic [DATA_W-1:0] iread_data,
    input  logic              iread_ack,
    output logic              owrite_req,
    output logic [ADDR_W-1:0] owrite_address,
    output logic [DATA_W-1:0] owrite_data,
    input  logic              iwrite_ack,
    input  logic              iin_use,
    output logic              obusy
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t state;
    logic last_data, grant_data, op_we, fetch_win, data_win, unused_in_use;
    // Fetch wins a tie unless it was the last client served.
    assign fetch_win     = ifetch_req && (!idata_req || last_data);
    assign data_win      = idata_req && !fetch_win;
    assign ofetch_accept = (state == IDLE) && fetch_win;
    assign odata_accept  = (state == IDLE) && data_win;
    assign obusy         = (state != IDLE);
    assign unused_in_use = iin_use;
    always_ff @(posedge iclk) begin
        if (!ireset) begin
            state          <= IDLE;
            last_data      <= 1'b1;
            grant_data     <= 1'b0;
            op_we          <= 1'b0;
            oread_req      <= 1'b0;
            owrite_req     <= 1'b0;
            oread_address  <= '0;
            owrite_address <= '0;
            owrite_data    <= '0;
            ofetch_valid   <= 1'b0;
            odata_valid    <= 1'b0;
            ofetch_data    <= '0;
            odata_rdata    <= '0;
        end else begin
            ofetch_valid <= 1'b0;
            odata_valid  <= 1'b0;
            case (state)
                IDLE: if (fetch_win || data_win) begin
                    grant_data <= data_win;
                    op_we      <= data_win && idata_we;
                    if (data_win && idata_we) begin
                        owrite_req     <= 1'b1;
                        owrite_address <= idata_address;
                        owrite_data    <= idata_wdata;
                    end else begin
                        oread_req     <= 1'b1;
                        oread_address <= data_win ? idata_address : ifetch_address;
                    end
                    state <= ISSUE;
                end
                ISSUE: if (!op_we && iread_ack) begin
                    oread_req <= 1'b0;
                    state     <= RESP;
                    if (grant_data) begin
                        odata_valid <= 1'b1;
                        odata_rdata <= iread_data;
                    end else begin
                        ofetch_valid <= 1'b1;
                        ofetch_data  <= iread_data;
                    end
                end else if (op_we && iwrite_ack) begin
                    owrite_req  <= 1'b0;
                    odata_valid <= 1'b1;
                    odata_rdata <= '0;
                    state       <= RESP;
                end
                RESP: begin
                    last_data <= grant_data;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sdram_mem_arbiter.md
Name: sdram_mem_arbiter

Overview:
- Sits directly upstream of the SDRAM controller and is the only block that drives its read/write request interface.
- Arbitrates between two clients, one transaction at a time:
  - instruction-fetch port: read-only.
  - data port: read or write.
- Holds the controller request until the matching ack arrives, captures returned read data, and returns a one-cycle response to the granted client.
- Round-robin priority stops either client from starving the other.

Parameters:
- ADDR_W, 22, block address width; one address = one DATA_W block in SDRAM.
- DATA_W, 128, block width; equals the controller's data block size (8 x 16-bit beats).

Ports:
- iclk  in  1  system clock.
- ireset  in  1  reset; one clock; reset is synchronous and active-low.
- ifetch_req  in  1  fetch client requests a block read.
- ifetch_address  in  ADDR_W  fetch block address.
- ofetch_accept  out  1  request taken this cycle.
- ofetch_valid  out  1  one-cycle pulse: ofetch_data valid.
- ofetch_data  out  DATA_W  fetched block.
- idata_req  in  1  data client request.
- idata_we  in  1  1 = write, 0 = read.
- idata_address  in  ADDR_W  data block address.
- idata_wdata  in  DATA_W  write block.
- odata_accept  out  1  request taken this cycle.
- odata_valid  out  1  one-cycle pulse: read data valid or write complete.
- odata_rdata  out  DATA_W  read block; 0 after a write.
- oread_req  out  1  to controller read request.
- oread_address  out  ADDR_W  to controller.
- iread_data  in  DATA_W  from controller; valid while iread_ack = 1.
- iread_ack  in  1  controller read done, one-cycle pulse.
- owrite_req  out  1  to controller write request.
- owrite_address  out  ADDR_W  to controller.
- owrite_data  out  DATA_W  to controller.
- iwrite_ack  in  1  controller write done, one-cycle pulse.
- iin_use  in  1  controller busy flag; status only.
- obusy  out  1  arbiter not in IDLE.

Behaviour:
- Reset (ireset = 0 at a clock edge):
  - state = IDLE; last_grant = DATA, so fetch wins the first tie.
  - All outputs 0: req, valid and accept flags, address, data and rdata registers.
  - Any in-flight transaction is abandoned; no response pulse is issued.
  - The controller is reset by the top level from the same source.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - Grant selection:
    - Only one client has req high: grant that client.
    - Both high: grant the client that is not last_grant.
  - The accept flag for the granted port is combinational and high in this same cycle; the other port's accept stays 0.
  - At the edge, latch into holding registers:
    - op = read, or idata_we for the data port.
    - address; write data if the op is a write.
    - grant.
  - At the same edge, set oread_req or owrite_req = 1 (never both) and go to ISSUE.
  - No req high: stay in IDLE.
- ISSUE:
  - Hold the req flag, address and data constant.
  - Read op: when iread_ack = 1:
    - Capture iread_data into the response register.
    - Clear oread_req at the same edge, so it is low in the controller's next IDLE cycle and the read is not re-issued.
    - Go to RESP.
  - Write op: when iwrite_ack = 1: clear owrite_req, set the response register to 0, go to RESP.
  - An ack of the wrong type is ignored. Acks seen in IDLE or RESP are ignored.
  - No timeout: the first request may wait through the whole controller initialization.
- RESP:
  - The granted port's valid flag is high for exactly one cycle.
  - Its data output holds the response register. The data outputs keep their value until the next response.
  - last_grant <= grant; go to IDLE.
- Latency: accept cycle A, controller request visible A+1, ack cycle K, client valid K+1.
- New requests are accepted only in IDLE, so the next accept is at K+2 at the earliest. Clients keep req and operands stable until accepted.
- A client that drops req before it is accepted has no effect.
- ifetch_req is never treated as a write.
- obusy = (state != IDLE).

Test Plan:
- Reset, then fetch read of 0x000010; controller acks 5 cycles after the request with data 0x0123..CDEF -> ofetch_accept in cycle 0, oread_req from cycle 1 to the ack edge, ofetch_valid one cycle with 0x0123..CDEF, oread_req low in the cycle after the ack.
- Data write of 0x3FFFFF with data all-ones -> owrite_address 0x3FFFFF and owrite_data all-ones stable until iwrite_ack; odata_valid pulses once with odata_rdata 0; oread_req stays 0.
- Both ports request continuously for 6 transactions -> grants alternate FETCH, DATA, FETCH, ...; never two accepts in the same cycle.
- Spurious iwrite_ack pulse while a read is in ISSUE, and an ack pulse in IDLE -> ignored; no valid pulse; the read completes only on iread_ack.
- ireset driven low for 1 cycle during ISSUE -> all outputs 0 the next cycle, no valid pulse; a new fetch after release runs with fetch priority.
